social_battery_manager: RTL and testbench
=========================================

// Module: social_battery_manager
// PURPOSE
//   Downstream consumer of the 2-bit mood code from introvert_help
//   (00 calm, 01 mild, 10 anxious, 11 overwhelmed). Debounces the code and
//   drains or recharges a saturating "social battery" counter from it.
//   Requests an exit through a req/ack handshake when the battery is empty,
//   then runs a forced recovery phase.
// PARAMETERS
//   BATT_W     8    battery counter width
//   BATT_MAX   200  full/reset battery value (< 2**BATT_W)
//   LOW_TH     64   low-warning threshold, also the recovery exit level
//   HOLD       3    consecutive identical valid samples before a code takes effect (>=1)
//   RECHARGE   1    charge step per valid sample when effective code = 00
//   DRAIN_MILD 1    drain step per valid sample, code 01
//   DRAIN_ANX  2    drain step per valid sample, code 10
//   DRAIN_OVR  4    drain step per valid sample, code 11
// PORTS
//   clk        in   1       single clock, rising edge
//   reset      in   1       asynchronous, active-low reset
//   mood_valid in   1       mood is sampled on edges where this is 1
//   mood       in   2       mood code from the upstream stage
//   exit_ack   in   1       acknowledge for exit_req
//   battery    out  BATT_W  current battery level (registered)
//   state      out  2       00 NORMAL, 01 LOW, 10 DRAINED, 11 RECOVER
//   low_warn   out  1       1 when state is LOW or DRAINED
//   exit_req   out  1       exit request, held until acknowledged
// BEHAVIOUR
//   Reset (reset==0, async): battery=BATT_MAX, state=NORMAL, low_warn=0,
//     exit_req=0, effective code eff=00, filter cand=00, cnt=0.
//   Filter, on each valid sample:
//     mood!=cand -> cand<=mood, cnt<=1
//     else       -> cnt<=min(cnt+1,HOLD)
//     eff<=mood on the sample where the new cnt equals HOLD.
//     HOLD=1 makes eff follow every valid sample.
//   Battery, on each valid sample, uses the eff value held before that edge:
//     eff 00 adds RECHARGE; 01/10/11 subtract the DRAIN step.
//     Saturates at BATT_MAX and at 0; never wraps.
//     In DRAINED, battery is frozen.
//     In RECOVER, +2*RECHARGE per valid sample regardless of eff (saturating).
//     No valid sample -> battery holds.
//   FSM evaluates the registered battery, so state lags battery by one cycle:
//     NORMAL  -> LOW     if battery<LOW_TH
//     LOW     -> NORMAL  if battery>=LOW_TH
//     LOW     -> DRAINED if battery==0
//     NORMAL  -> DRAINED if battery==0 (priority over LOW)
//     DRAINED -> RECOVER on exit_ack==1 while exit_req==1
//     RECOVER -> NORMAL  if battery>=LOW_TH
//   exit_req is registered:
//     rises on the same edge that enters DRAINED; stays 1 with no ack;
//     clears on the edge that leaves DRAINED.
//     exit_ack in any other state is ignored, including the DRAINED-entry cycle.
//   mood_valid and mood are ignored while in DRAINED; the filter holds.
// CONFIGURATION
//   BATTERY_STATS_EN defined:
//     adds port drain_count out 16, number of DRAINED entries,
//     saturating at 16'hFFFF, reset 0.
//   BATTERY_STATS_EN undefined: the port and counter are absent.
//     All other behaviour is identical.
// TESTING
//   1 Reset release
//     -> battery=200, state=00, exit_req=0, low_warn=0
//   2 mood=11 for 2 valid samples, then 00 steady
//     -> battery stays 200, eff stays 00
//   3 mood=10 continuous valid
//     -> eff=10 at 3rd edge; -2 from 4th sample
//     -> battery=62 after 69 drains; state=01, low_warn=1 one cycle later
//   4 mood=11 until battery=0
//     -> state=10, exit_req=1; held 10 cycles without ack, battery stays 0
//     -> ack pulse: state=11, exit_req=0
//     -> +2 per valid sample; state=00 once battery>=64 (32 samples)
//   5 reset driven low mid-RECOVER, between edges
//     -> outputs take reset values immediately
//   6 RECHARGE=4, battery=199, eff=00, one valid sample -> battery=200;
//     DRAIN_OVR=4, battery=3, eff=11 -> battery=0;
//     with BATTERY_STATS_EN, two DRAINED entries -> drain_count=2

Source files
------------

// File: rtl/social_battery_manager.sv
// Debounces the mood code and drains or recharges a saturating social battery.
// It requests an exit when the battery is empty, then runs a forced recovery.
// Define BATTERY_STATS_EN to add the drain_count port, which counts DRAINED entries.
module social_battery_manager #(
    parameter int unsigned BATT_W     = 8,
    parameter int unsigned BATT_MAX   = 200,
    parameter int unsigned LOW_TH     = 64,
    parameter int unsigned HOLD       = 3,
    parameter int unsigned RECHARGE   = 1,
    parameter int unsigned DRAIN_MILD = 1,
    parameter int unsigned DRAIN_ANX  = 2,
    parameter int unsigned DRAIN_OVR  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mood_valid,
    input  logic [1:0]        mood,
    input  logic              exit_ack,
    output logic [BATT_W-1:0] battery,
    output logic [1:0]        state,
    output logic              low_warn,
    output logic              exit_req
`ifdef BATTERY_STATS_EN
    ,
    output logic [15:0]       drain_count
`endif
);
    typedef enum logic [1:0] {
        NORMAL  = 2'b00,
        LOW     = 2'b01,
        DRAINED = 2'b10,
        RECOVER = 2'b11
    } state_t;

    localparam int CW = $clog2(HOLD + 1);
    localparam int SW = BATT_W + 4;
    localparam logic [SW-1:0]     MAX_E  = SW'(BATT_MAX);
    localparam logic [BATT_W-1:0] MAX_B  = BATT_W'(BATT_MAX);
    localparam logic [BATT_W-1:0] LOW_B  = BATT_W'(LOW_TH);
    localparam logic [CW-1:0]     HOLD_C = CW'(HOLD);

    state_t            st_q, st_d;
    logic [1:0]        cand_q, eff_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     step, up, batt_ext;
    logic [BATT_W-1:0] batt_d;
    logic              sample, charge;

    // The filter and battery are frozen while DRAINED.
    assign sample = mood_valid && (st_q != DRAINED);

    always_comb begin
        cnt_d = CW'(1);
        if (mood == cand_q)
            cnt_d = (cnt_q >= HOLD_C) ? HOLD_C : cnt_q + CW'(1);
    end

    always_comb begin
        batt_ext = SW'(battery);
        charge   = (st_q == RECOVER) || (eff_q == 2'b00);
        step     = SW'(RECHARGE);
        if (st_q == RECOVER)
            step = SW'(2 * RECHARGE);
        else begin
            case (eff_q)
                2'b00:   step = SW'(RECHARGE);
                2'b01:   step = SW'(DRAIN_MILD);
                2'b10:   step = SW'(DRAIN_ANX);
                default: step = SW'(DRAIN_OVR);
            endcase
        end
        up     = batt_ext + step;
        batt_d = battery;
        if (sample) begin
            if (charge)
                batt_d = (up > MAX_E) ? MAX_B : up[BATT_W-1:0];
            else
                batt_d = (batt_ext < step) ? '0 : battery - step[BATT_W-1:0];
        end
    end

    // The FSM looks at the registered battery, so it lags the battery by one cycle.
    always_comb begin
        st_d = st_q;
        case (st_q)
            NORMAL:  if (battery == '0) st_d = DRAINED;
                     else if (battery < LOW_B) st_d = LOW;
            LOW:     if (battery == '0) st_d = DRAINED;
                     else if (battery >= LOW_B) st_d = NORMAL;
            DRAINED: if (exit_ack && exit_req) st_d = RECOVER;
            RECOVER: if (battery >= LOW_B) st_d = NORMAL;
            default: st_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            battery  <= MAX_B;
            st_q     <= NORMAL;
            exit_req <= 1'b0;
            eff_q    <= 2'b00;
            cand_q   <= 2'b00;
            cnt_q    <= '0;
        end else begin
            battery  <= batt_d;
            st_q     <= st_d;
            exit_req <= (st_d == DRAINED);
            if (sample) begin
                cand_q <= mood;
                cnt_q  <= cnt_d;
                if (cnt_d == HOLD_C) eff_q <= mood;
            end
        end
    end

`ifdef BATTERY_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            drain_count <= '0;
        else if (st_d == DRAINED && st_q != DRAINED && drain_count != 16'hFFFF)
            drain_count <= drain_count + 16'd1;
    end
`endif

    assign state    = st_q;
    assign low_warn = (st_q == LOW) || (st_q == DRAINED);
endmodule

// File: tb/tb_social_battery_manager.sv
// Bench for social_battery_manager: a directed table, multi-cycle corner cases,
// and random traffic checked against a behavioural model.
module tb_social_battery_manager;
    localparam int BMAX = 200, LTH = 64, HOLD = 3, RCH = 1;

    logic       clk = 0, reset = 0, mood_valid = 0, exit_ack = 0;
    logic [1:0] mood = 0;
    logic [7:0] battery;
    logic [1:0] state;
    logic       low_warn, exit_req;
    logic       v2 = 0, a2 = 0;
    logic [1:0] m2 = 0;
    logic [7:0] battery2;
    logic [1:0] state2;
    logic       low_warn2, exit_req2;
`ifdef BATTERY_STATS_EN
    logic [15:0] drain_count, drain_count2;
`endif

    social_battery_manager dut (
        .clk(clk), .reset(reset), .mood_valid(mood_valid), .mood(mood),
        .exit_ack(exit_ack), .battery(battery), .state(state),
        .low_warn(low_warn), .exit_req(exit_req)
`ifdef BATTERY_STATS_EN
        , .drain_count(drain_count)
`endif
    );

    social_battery_manager #(.RECHARGE(4)) dut2 (
        .clk(clk), .reset(reset), .mood_valid(v2), .mood(m2),
        .exit_ack(a2), .battery(battery2), .state(state2),
        .low_warn(low_warn2), .exit_req(exit_req2)
`ifdef BATTERY_STATS_EN
        , .drain_count(drain_count2)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: a code becomes effective once the last HOLD samples agree.
    int m_batt, m_st, m_eff, m_req, m_dc;
    int hist[$];

    function automatic int drain_of(input int e);
        case (e)
            1:       return 1;
            2:       return 2;
            default: return 4;
        endcase
    endfunction

    task automatic model_reset();
        m_batt = BMAX; m_st = 0; m_eff = 0; m_req = 0; m_dc = 0;
        hist.delete();
    endtask

    task automatic model_step(input int v, input int m, input int a);
        int nb, ns;
        bit same;
        nb = m_batt;
        ns = m_st;
        if (v != 0 && m_st != 2) begin
            if (m_st == 3)
                nb = (m_batt + 2 * RCH > BMAX) ? BMAX : m_batt + 2 * RCH;
            else if (m_eff == 0)
                nb = (m_batt + RCH > BMAX) ? BMAX : m_batt + RCH;
            else
                nb = (m_batt < drain_of(m_eff)) ? 0 : m_batt - drain_of(m_eff);
            hist.push_back(m);
            if (hist.size() > HOLD) void'(hist.pop_front());
            same = (hist.size() == HOLD);
            foreach (hist[i]) if (hist[i] != m) same = 0;
            if (same) m_eff = m;
        end
        case (m_st)
            0: if (m_batt == 0) ns = 2; else if (m_batt < LTH) ns = 1;
            1: if (m_batt == 0) ns = 2; else if (m_batt >= LTH) ns = 0;
            2: if (a != 0 && m_req != 0) ns = 3;
            default: if (m_batt >= LTH) ns = 0;
        endcase
        if (ns == 2 && m_st != 2 && m_dc < 65535) m_dc++;
        m_req  = (ns == 2);
        m_batt = nb;
        m_st   = ns;
    endtask

    task automatic cycle(input int v, input int m, input int a);
        mood_valid = v[0];
        mood       = m[1:0];
        exit_ack   = a[0];
        @(posedge clk);
        model_step(v, m, a);
        @(negedge clk);
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, " battery"}, battery, m_batt);
        chk({tag, " state"}, state, m_st);
        chk({tag, " exit_req"}, exit_req, m_req);
        chk({tag, " low_warn"}, low_warn, (m_st == 1 || m_st == 2));
`ifdef BATTERY_STATS_EN
        chk({tag, " drain_count"}, drain_count, m_dc);
`endif
    endtask

    typedef struct {
        int n, v, m, a;
        int eb, es, el, er;
    } vec_t;
    vec_t tbl[15];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{0,  0, 0, 0, 200, 0, 0, 0};
        tbl[1]  = '{2,  1, 3, 0, 200, 0, 0, 0};
        tbl[2]  = '{5,  1, 0, 0, 200, 0, 0, 0};
        tbl[3]  = '{3,  1, 2, 0, 200, 0, 0, 0};
        tbl[4]  = '{1,  1, 2, 0, 198, 0, 0, 0};
        tbl[5]  = '{68, 1, 2, 0, 62,  0, 0, 0};
        tbl[6]  = '{1,  0, 2, 0, 62,  1, 1, 0};
        tbl[7]  = '{3,  1, 3, 0, 56,  1, 1, 0};
        tbl[8]  = '{14, 1, 3, 0, 0,   1, 1, 0};
        tbl[9]  = '{1,  1, 3, 1, 0,   2, 1, 1};
        tbl[10] = '{10, 1, 0, 0, 0,   2, 1, 1};
        tbl[11] = '{1,  1, 0, 1, 0,   3, 0, 0};
        tbl[12] = '{31, 1, 0, 0, 62,  3, 0, 0};
        tbl[13] = '{1,  1, 0, 0, 64,  3, 0, 0};
        tbl[14] = '{1,  0, 0, 0, 64,  0, 0, 0};

        model_reset();
        repeat (2) @(negedge clk);
        reset = 1;

        for (int i = 0; i < 15; i++) begin
            repeat (tbl[i].n) cycle(tbl[i].v, tbl[i].m, tbl[i].a);
            chk($sformatf("row%0d battery", i), battery, tbl[i].eb);
            chk($sformatf("row%0d state", i), state, tbl[i].es);
            chk($sformatf("row%0d low_warn", i), low_warn, tbl[i].el);
            chk($sformatf("row%0d exit_req", i), exit_req, tbl[i].er);
        end

        // Second drain, then an asynchronous reset in the middle of RECOVER.
        for (int k = 0; k < 400 && !exit_req; k++) cycle(1, 3, 0);
        chk("drain2 exit_req", exit_req, 1);
        cycle(1, 0, 1);
        chk("drain2 state", state, 3);
        chk("drain2 exit_req cleared", exit_req, 0);
        repeat (3) cycle(1, 0, 0);
        cmp_model("recover");
`ifdef BATTERY_STATS_EN
        chk("drain_count two entries", drain_count, 2);
`endif
        #2 reset = 0;
        #1;
        chk("async battery", battery, 200);
        chk("async state", state, 0);
        chk("async exit_req", exit_req, 0);
        chk("async low_warn", low_warn, 0);
`ifdef BATTERY_STATS_EN
        chk("async drain_count", drain_count, 0);
`endif
        model_reset();
        @(negedge clk);
        reset = 1;

        for (int ph = 0; ph < 4; ph++) begin
            for (int k = 0; k < 800; k++) begin
                int v, m, a, r, bias;
                bias = (ph == 0) ? 10 : (ph == 1) ? 60 : (ph == 2) ? 30 : 80;
                v = ($urandom_range(0, 9) < 8) ? 1 : 0;
                r = $urandom_range(0, 99);
                m = (r < bias) ? 3 : ((r % 3 == 0) ? 0 : $urandom_range(0, 3));
                a = ($urandom_range(0, 7) == 0) ? 1 : 0;
                cycle(v, m, a);
                cmp_model($sformatf("rand ph%0d cyc%0d", ph, k));
            end
        end

        // Recharge saturation on the instance with a larger charge step.
        a2 = 0;
        for (int k = 0; k < 6; k++) begin
            v2 = 1;
            m2 = (k < 3) ? 2'b01 : 2'b00;
            @(posedge clk);
            @(negedge clk);
        end
        chk("dut2 battery before charge", battery2, 197);
        @(posedge clk);
        @(negedge clk);
        chk("dut2 battery saturated", battery2, 200);
        chk("dut2 state", state2, 0);
        v2 = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
